tone_direction_decoder: RTL and testbench

//  Upstream of the drive state machine. Qualifies five band-pass detector outputs
//  (bp1..bp5) by pulse rate over fixed windows and issues a debounced junction command.

---
 rtl/tone_direction_decoder_pkg.sv | 50 +++++
 rtl/tone_direction_decoder_if.sv | 30 +++
 rtl/tone_channel.sv | 61 ++++++
 rtl/tone_direction_decoder.sv | 150 +++++++++++++++
 tb/tb_tone_direction_decoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/tone_direction_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tone_direction_decoder_pkg                                 |
// | Description : Shared types and defaults for the tone direction decoder.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package tone_direction_decoder_pkg;

    localparam int DEF_WINDOW_CYCLES   = 500_000;
    localparam int DEF_MIN_EDGES       = 8;
    localparam int DEF_MAX_EDGES       = 40;
    localparam int DEF_CONFIRM_WINDOWS = 3;
    localparam int DEF_HOLD_WINDOWS    = 20;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = 255;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONFIRM = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CLS_SILENT   = 2'b00,
        CLS_VALID    = 2'b01,
        CLS_CONFLICT = 2'b10,
        CLS_CANCEL   = 2'b11
    } win_class_t;

    // Maps a one-hot direction-channel activity vector (bp1 in bit 0) to a code.
    function automatic dir_t onehot_dir(input logic [3:0] oh);
        case (oh)
            4'b0010: onehot_dir = DIR_LEFT;
            4'b0100: onehot_dir = DIR_RIGHT;
            4'b1000: onehot_dir = DIR_BACK;
            default: onehot_dir = DIR_STRAIGHT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_direction_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tone_direction_decoder_if                                  |
// | Description : Detector inputs and junction command outputs.              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface tone_direction_decoder_if;
    import tone_direction_decoder_pkg::*;

    logic   bp1;
    logic   bp2;
    logic   bp3;
    logic   bp4;
    logic   bp5;
    logic   td_en;
    dir_t   td_dir;
    state_t td_state;

    modport master (
        output bp1, bp2, bp3, bp4, bp5,
        input  td_en, td_dir, td_state
    );

    modport slave (
        input  bp1, bp2, bp3, bp4, bp5,
        output td_en, td_dir, td_state
    );

endinterface
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tone_channel                                               |
// | Description : Synchronises one detector, counts rising edges per window  |
// |               and flags the channel active when the rate is in range.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tone_channel
    import tone_direction_decoder_pkg::*;
#(
    parameter int MIN_EDGES = DEF_MIN_EDGES,
    parameter int MAX_EDGES = DEF_MAX_EDGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bp_i,
    input  logic win_end_i,
    output logic active_o
);

    localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'((MAX_EDGES > CNT_MAX) ? CNT_MAX : MAX_EDGES);
    localparam logic [CNT_W-1:0] C_SAT = CNT_W'(CNT_MAX);

    logic             sync1_q, sync2_q, sync3_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_close;
    logic             active_q, active_d;

    assign rise = sync2_q & ~sync3_q;

    // An edge landing in the win_end cycle belongs to the closing window.
    always_comb begin
        cnt_close = cnt_q;
        if (rise && (cnt_q != C_SAT)) begin
            cnt_close = cnt_q + CNT_W'(1);
        end
        cnt_d    = win_end_i ? '0 : cnt_close;
        active_d = win_end_i ? ((cnt_close >= C_MIN) && (cnt_close <= C_MAX)) : active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sync1_q  <= bp_i;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/tone_direction_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tone_direction_decoder                                     |
// | Description : Window timing, per-window classification and lock FSM     |
// |               producing the debounced junction command.                  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tone_direction_decoder
    import tone_direction_decoder_pkg::*;
#(
    parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int MIN_EDGES       = DEF_MIN_EDGES,
    parameter int MAX_EDGES       = DEF_MAX_EDGES,
    parameter int CONFIRM_WINDOWS = DEF_CONFIRM_WINDOWS,
    parameter int HOLD_WINDOWS    = DEF_HOLD_WINDOWS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tone_direction_decoder_if.slave  bus
);

    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int CW = $clog2(CONFIRM_WINDOWS + 1);
    localparam int HW = $clog2(HOLD_WINDOWS + 1);
    localparam logic [WW-1:0] C_WIN_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [CW-1:0] C_CONFIRM  = CW'(CONFIRM_WINDOWS);
    localparam logic [HW-1:0] C_HOLD     = HW'(HOLD_WINDOWS);

    logic [WW-1:0]     win_cnt_q, win_cnt_d;
    logic              win_end;
    logic              eval_q;
    logic [NUM_CH-1:0] bp_vec;
    logic [NUM_CH-1:0] active;
    win_class_t        win_class;
    dir_t              win_code;
    state_t            state_q, state_d;
    dir_t              cand_q, cand_d, dir_q, dir_d;
    logic              en_q, en_d;
    logic [CW-1:0]     conf_q, conf_d;
    logic [HW-1:0]     silent_q, silent_d;

    assign win_end   = (win_cnt_q == C_WIN_LAST);
    assign win_cnt_d = win_end ? '0 : win_cnt_q + WW'(1);

    assign bp_vec = {bus.bp5, bus.bp4, bus.bp3, bus.bp2, bus.bp1};

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        tone_channel #(
            .MIN_EDGES (MIN_EDGES),
            .MAX_EDGES (MAX_EDGES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .bp_i      (bp_vec[gi]),
            .win_end_i (win_end),
            .active_o  (active[gi])
        );
    end

    // Cancel tone overrides any direction activity.
    always_comb begin
        win_class = CLS_SILENT;
        win_code  = onehot_dir(active[3:0]);
        if (active[4]) begin
            win_class = CLS_CANCEL;
        end else begin
            case (active[3:0])
                4'b0000:                            win_class = CLS_SILENT;
                4'b0001, 4'b0010, 4'b0100, 4'b1000: win_class = CLS_VALID;
                default:                            win_class = CLS_CONFLICT;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        conf_d   = conf_q;
        silent_d = silent_q;
        if (eval_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_class == CLS_VALID) begin
                        cand_d   = win_code;
                        conf_d   = CW'(1);
                        silent_d = '0;
                        state_d  = (CONFIRM_WINDOWS <= 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (win_class != CLS_VALID) begin
                        state_d = ST_IDLE;
                    end else if (win_code != cand_q) begin
                        cand_d = win_code;
                        conf_d = CW'(1);
                    end else begin
                        conf_d = conf_q + CW'(1);
                        if ((conf_q + CW'(1)) == C_CONFIRM) begin
                            silent_d = '0;
                            state_d  = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (win_class == CLS_CANCEL) begin
                        state_d = ST_IDLE;
                    end else if (win_class == CLS_SILENT) begin
                        silent_d = silent_q + HW'(1);
                        if ((silent_q + HW'(1)) == C_HOLD) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        silent_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        en_d  = (state_d == ST_LOCKED);
        dir_d = en_d ? cand_d : dir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            eval_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cand_q    <= DIR_STRAIGHT;
            conf_q    <= '0;
            silent_q  <= '0;
            en_q      <= 1'b0;
            dir_q     <= DIR_STRAIGHT;
        end else begin
            win_cnt_q <= win_cnt_d;
            eval_q    <= win_end;
            state_q   <= state_d;
            cand_q    <= cand_d;
            conf_q    <= conf_d;
            silent_q  <= silent_d;
            en_q      <= en_d;
            dir_q     <= dir_d;
        end
    end

    assign bus.td_en    = en_q;
    assign bus.td_dir   = dir_q;
    assign bus.td_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_direction_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tone_direction_decoder                                  |
// | Description : Window-aligned directed stimulus with a scoreboard of      |
// |               expected junction commands per window.                     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_tone_direction_decoder;

    localparam int N           = 1000;
    localparam int MIN_E       = 4;
    localparam int MAX_E       = 20;
    localparam int CONF        = 3;
    localparam int HOLD        = 2;
    localparam int PULSE_START = 50;

    localparam logic [5:1] B0 = 5'b00000;
    localparam logic [5:1] B1 = 5'b00001;
    localparam logic [5:1] B2 = 5'b00010;
    localparam logic [5:1] B3 = 5'b00100;
    localparam logic [5:1] B4 = 5'b01000;
    localparam logic [5:1] B5 = 5'b10000;

    typedef struct packed {
        logic       en;
        logic [1:0] dir;
        logic [1:0] st;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t sb[$];
    exp_t cur;

    int         m_state;
    int         m_conf;
    int         m_silent;
    logic [1:0] m_cand;
    logic [1:0] m_dir;
    logic       m_en;

    tone_direction_decoder_if bus ();

    tone_direction_decoder #(
        .WINDOW_CYCLES   (N),
        .MIN_EDGES       (MIN_E),
        .MAX_EDGES       (MAX_E),
        .CONFIRM_WINDOWS (CONF),
        .HOLD_WINDOWS    (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic set_bp(input logic [5:1] v);
        {bus.bp5, bus.bp4, bus.bp3, bus.bp2, bus.bp1} = v;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        n_tests += 3;
        assert (bus.td_en === e.en) else begin
            n_fail++;
            $error("FAIL %s td_en observed=%0b expected=%0b", tag, bus.td_en, e.en);
        end
        assert (bus.td_dir === e.dir) else begin
            n_fail++;
            $error("FAIL %s td_dir observed=%0b expected=%0b", tag, bus.td_dir, e.dir);
        end
        assert (bus.td_state === e.st) else begin
            n_fail++;
            $error("FAIL %s td_state observed=%0b expected=%0b", tag, bus.td_state, e.st);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_conf   = 0;
        m_silent = 0;
        m_cand   = 2'b00;
        m_dir    = 2'b00;
        m_en     = 1'b0;
        cur      = '0;
        sb.delete();
    endtask

    // Behavioural reference: classify the window from the pulse count, then step the lock machine.
    task automatic model_window(input logic [5:1] mask, input int n);
        int         sat;
        int         nact;
        logic [5:1] act;
        logic [1:0] code;
        logic       valid, silent, cancel;
        exp_t       e;
        sat  = (n > 255) ? 255 : n;
        act  = (sat >= MIN_E && sat <= MAX_E) ? mask : 5'b0;
        nact = int'(act[1]) + int'(act[2]) + int'(act[3]) + int'(act[4]);
        code = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            if (act[i]) code = 2'(i - 1);
        end
        cancel = act[5];
        valid  = !cancel && (nact == 1);
        silent = !cancel && (nact == 0);
        case (m_state)
            0: if (valid) begin
                m_cand   = code;
                m_conf   = 1;
                m_silent = 0;
                m_state  = (m_conf >= CONF) ? 2 : 1;
            end
            1: if (valid) begin
                if (code == m_cand) begin
                    m_conf++;
                end else begin
                    m_cand = code;
                    m_conf = 1;
                end
                if (m_conf >= CONF) begin
                    m_state  = 2;
                    m_silent = 0;
                end
            end else begin
                m_state = 0;
            end
            default: if (cancel) begin
                m_state = 0;
            end else if (silent) begin
                m_silent++;
                if (m_silent >= HOLD) m_state = 0;
            end else begin
                m_silent = 0;
            end
        endcase
        m_en = (m_state == 2);
        if (m_en) m_dir = m_cand;
        e.en  = m_en;
        e.dir = m_dir;
        e.st  = 2'(m_state);
        sb.push_back(e);
    endtask

    // One window of len cycles; the previous window's decision must appear exactly at c==1.
    task automatic run_window(input logic [5:1] mask, input int n, input int len);
        int keep;
        keep = (len == N) ? 1 : 0;
        if (len == N) model_window(mask, n);
        for (int c = 0; c < len; c++) begin
            if (c == 0) check_out("hold", cur);
            if (c == 1 && sb.size() > keep) begin
                cur = sb.pop_front();
                check_out("decide", cur);
            end
            set_bp((c >= PULSE_START && c < PULSE_START + 2 * n &&
                    ((c - PULSE_START) % 2 == 0)) ? mask : B0);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            set_bp(5'($urandom));
            @(negedge clk);
        end
        check_out("reset", '0);
        set_bp(B0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        set_bp(B0);
        model_reset();
        do_reset(20);

        repeat (3) run_window(B2, 10, N);
        repeat (2) run_window(B0, 0, N);
        repeat (2) run_window(B1 | B3, 10, N);
        repeat (3) run_window(B2, 10, N);
        run_window(B0, 0, N);
        run_window(B2, 10, N);
        run_window(B1 | B3, 10, N);
        run_window(B5, 10, N);

        repeat (3) run_window(B4, 3, N);
        repeat (3) run_window(B4, 300, N);

        run_window(B1, 10, N);
        repeat (3) run_window(B3, 10, N);
        run_window(B5, 10, N);

        run_window(B2, 10, N);
        run_window(B2, 10, N / 2);
        do_reset(10);
        repeat (3) run_window(B2, 10, N);
        run_window(B0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
